aes_cipher_collector: RTL and testbench

- Sits directly downstream of aes_engine and consumes its byte-serial ciphertext stream (dout/data_ok).
- Reassembles each group of 16 bytes into one 128-bit ciphertext block.
- Buffers completed blocks in a small FIFO and presents them on a valid/ready interface to the system side.
- Detects truncated blocks with a gap timeout and detects overflow, because aes_engine has no backpressure input.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_block_fifo.sv | 61 ++++++
 rtl/aes_cipher_collector.sv | 115 +++++++++++
 tb/tb_aes_cipher_collector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES ciphertext collector slice.
// Block geometry, collector state encoding and the byte-lane helper.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = 128;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  // Byte 0 lands in the top lane, byte 15 in the bottom one.
  function automatic logic [6:0] lane_lo(input logic [3:0] idx);
    return 7'(BLOCK_W - 8 - 8 * int'(idx));
  endfunction

endpackage

// File: rtl/aes_block_fifo.sv
// Synchronous DEPTH x BLOCK_W FIFO with a registered head-of-queue output.
// The head register holds its last value while the FIFO is empty.
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [AW-1:0]      rptr_n;
  logic [AW:0]        cnt;
  logic [AW:0]        cnt_n;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rptr_n  = do_pop ? rptr + 1'b1 : rptr;

  always_comb begin
    cnt_n = cnt;
    if (do_push && !do_pop) cnt_n = cnt + 1'b1;
    if (!do_push && do_pop) cnt_n = cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr <= rptr_n;
      cnt  <= cnt_n;
      // Bypass the write when the new head is the slot being filled.
      if (cnt_n != '0)
        rdata <= (do_push && wptr == rptr_n) ? wdata : mem[rptr_n];
    end
  end

endmodule

// File: rtl/aes_cipher_collector.sv
// Reassembles aes_engine's byte stream into 128-bit blocks and queues them.
// No backpressure upstream, so drops and truncations are flagged sticky.
module aes_cipher_collector
  import aes_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int GAP_MAX = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         din,
  input  logic               din_ok,
  output logic [BLOCK_W-1:0] cipher_out,
  output logic               cipher_valid,
  input  logic               cipher_ready,
  output logic [CNT_W-1:0]   block_count,
  output logic               overflow_err,
  output logic               timeout_err,
  input  logic               err_clr,
  output logic               busy
);

  localparam int GW = $clog2(GAP_MAX + 1);

  state_t             state;
  logic [3:0]         idx;
  logic [GW-1:0]      gap;
  logic [BLOCK_W-1:0] blk;
  logic [BLOCK_W-1:0] blk_n;
  logic               last;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               ov_set;
  logic               to_set;

  assign cipher_valid = !empty;
  assign busy         = (state == COLLECT);
  assign pop          = cipher_valid && cipher_ready;
  assign last   = din_ok && (idx == 4'(BLOCK_BYTES - 1));
  assign push   = last && (!full || pop);
  assign ov_set = last && !push;
  assign to_set = (state == COLLECT) && !din_ok
               && (gap == GW'(GAP_MAX - 1));

  always_comb begin
    blk_n = blk;
    blk_n[lane_lo(idx) +: 8] = din;
  end

  aes_block_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (blk_n),
    .rdata (cipher_out),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      gap   <= '0;
      blk   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          gap <= '0;
          if (din_ok) begin
            blk   <= blk_n;
            idx   <= idx + 4'd1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (din_ok) begin
            blk <= blk_n;
            gap <= '0;
            idx <= idx + 4'd1;
            if (last) state <= IDLE;
          end else if (to_set) begin
            state <= IDLE;
            idx   <= '0;
            gap   <= '0;
          end else begin
            gap <= gap + 1'b1;
          end
        end
      endcase
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_count  <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (push) block_count <= block_count + 1'b1;
      if (ov_set) overflow_err <= 1'b1;
      else if (err_clr) overflow_err <= 1'b0;
      if (to_set) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Randomized and directed bench for aes_cipher_collector.
// Reference model: byte queue, block queue and plain counters.
module tb_aes_cipher_collector;

  localparam int DEPTH   = 2;
  localparam int GAP_MAX = 64;
  localparam int CNT_W   = 16;

  logic              clk;
  logic              rst;
  logic [7:0]        din;
  logic              din_ok;
  logic [127:0]      cipher_out;
  logic              cipher_valid;
  logic              cipher_ready;
  logic [CNT_W-1:0]  block_count;
  logic              overflow_err;
  logic              timeout_err;
  logic              err_clr;
  logic              busy;

  aes_cipher_collector #(
    .DEPTH   (DEPTH),
    .GAP_MAX (GAP_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_ok       (din_ok),
    .cipher_out   (cipher_out),
    .cipher_valid (cipher_valid),
    .cipher_ready (cipher_ready),
    .block_count  (block_count),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       m_bytes [$];
  logic [127:0]     m_q [$];
  int               m_gap;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ov;
  logic             m_to;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] seq(input logic [7:0] start);
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], 8'(start + 8'(i))};
    return b;
  endfunction

  task automatic check_all();
    chk("valid", 128'(cipher_valid), 128'(m_q.size() > 0));
    chk("count", 128'(block_count), 128'(m_cnt));
    chk("ovf",   128'(overflow_err), 128'(m_ov));
    chk("tmo",   128'(timeout_err), 128'(m_to));
    chk("busy",  128'(busy), 128'(m_bytes.size() > 0));
    if (m_q.size() > 0) chk("data", cipher_out, m_q[0]);
  endtask

  task automatic model(input logic [7:0] d, input logic ok,
                       input logic rdy, input logic clr);
    logic         pop;
    logic         ovs;
    logic         tos;
    logic [127:0] b;
    int           sz;
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
    ovs = 1'b0;
    tos = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (ok) begin
      m_bytes.push_back(d);
      m_gap = 0;
      if (m_bytes.size() == 16) begin
        b = '0;
        foreach (m_bytes[i]) b = {b[119:0], m_bytes[i]};
        if (sz < DEPTH || pop) begin
          m_q.push_back(b);
          m_cnt++;
        end else begin
          ovs = 1'b1;
        end
        m_bytes.delete();
      end
    end else if (m_bytes.size() > 0) begin
      m_gap++;
      if (m_gap == GAP_MAX) begin
        m_bytes.delete();
        m_gap = 0;
        tos = 1'b1;
      end
    end
    m_ov = ovs ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_to = tos ? 1'b1 : (clr ? 1'b0 : m_to);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [7:0] d, input logic ok,
                      input logic rdy, input logic clr);
    check_all();
    din          = d;
    din_ok       = ok;
    cipher_ready = rdy;
    err_clr      = clr;
    model(d, ok, rdy, clr);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_block(input logic [7:0] start, input logic rdy);
    for (int i = 0; i < 16; i++) step(8'(start + 8'(i)), 1'b1, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    din          = '0;
    din_ok       = 1'b0;
    cipher_ready = 1'b0;
    err_clr      = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 128'(cipher_valid), 128'd0);
      chk("rst_out",   cipher_out, 128'd0);
      chk("rst_count", 128'(block_count), 128'd0);
      chk("rst_ovf",   128'(overflow_err), 128'd0);
      chk("rst_tmo",   128'(timeout_err), 128'd0);
      chk("rst_busy",  128'(busy), 128'd0);
      if (k == 0) @(negedge clk);
    end
    m_bytes.delete();
    m_q.delete();
    m_gap = 0;
    m_cnt = '0;
    m_ov  = 1'b0;
    m_to  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Basic block, one-cycle latency.
    send_block(8'h00, 1'b1);
    chk("t1_valid", 128'(cipher_valid), 128'd1);
    chk("t1_out", cipher_out, 128'h000102030405060708090A0B0C0D0E0F);
    chk("t1_count", 128'(block_count), 128'd1);
    idle(3, 1'b1);

    // Overflow on the third back-to-back block.
    do_reset();
    send_block(8'h40, 1'b0);
    send_block(8'h50, 1'b0);
    send_block(8'h60, 1'b0);
    chk("t2_ovf", 128'(overflow_err), 128'd1);
    chk("t2_count", 128'(block_count), 128'd2);
    chk("t2_head", cipher_out, seq(8'h40));
    idle(4, 1'b1);
    chk("t2_drained", 128'(cipher_valid), 128'd0);

    // Pop and push in the same cycle on a full FIFO.
    do_reset();
    send_block(8'h20, 1'b0);
    send_block(8'h30, 1'b0);
    for (int i = 0; i < 15; i++) step(8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
    step(8'h8F, 1'b1, 1'b1, 1'b0);
    chk("t3_ovf", 128'(overflow_err), 128'd0);
    chk("t3_count", 128'(block_count), 128'd3);
    idle(4, 1'b1);

    // Gap timeout discards the stale partial block.
    do_reset();
    for (int i = 0; i < 5; i++) step(8'h70 + 8'(i), 1'b1, 1'b0, 1'b0);
    idle(GAP_MAX, 1'b0);
    chk("t4_tmo", 128'(timeout_err), 128'd1);
    chk("t4_busy", 128'(busy), 128'd0);
    send_block(8'hA0, 1'b0);
    chk("t4_out", cipher_out, seq(8'hA0));
    idle(2, 1'b1);

    // Gaps one short of the limit never time out.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      if (i < 15) idle(GAP_MAX - 1, 1'b0);
    end
    chk("t5_tmo", 128'(timeout_err), 128'd0);
    chk("t5_out", cipher_out, seq(8'h10));
    idle(2, 1'b1);

    // Reset in the middle of a block.
    do_reset();
    for (int i = 0; i < 8; i++) step(8'h90 + 8'(i), 1'b1, 1'b0, 1'b0);
    do_reset();
    send_block(8'hC0, 1'b0);
    chk("t6_out", cipher_out, seq(8'hC0));
    chk("t6_count", 128'(block_count), 128'd1);

    // Set beats clear; a later clear wins.
    do_reset();
    send_block(8'h01, 1'b0);
    send_block(8'h11, 1'b0);
    for (int i = 0; i < 15; i++) step(8'h21 + 8'(i), 1'b1, 1'b0, 1'b0);
    step(8'h30, 1'b1, 1'b0, 1'b1);
    chk("t7_ovf_set", 128'(overflow_err), 128'd1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("t7_ovf_clr", 128'(overflow_err), 128'd0);

    // Random traffic against the model.
    do_reset();
    for (int seg = 0; seg < 20; seg++) begin
      int p_ok;
      int p_rdy;
      p_ok  = $urandom_range(100, 5);
      p_rdy = $urandom_range(100, 0);
      if (seg % 5 == 4) begin
        for (int i = 0; i < 3; i++) step(8'($urandom), 1'b1, 1'b0, 1'b0);
        idle(GAP_MAX + 2, 1'b0);
      end
      for (int c = 0; c < 150; c++)
        step(8'($urandom),
             1'($urandom_range(99, 0) < p_ok),
             1'($urandom_range(99, 0) < p_rdy),
             1'($urandom_range(99, 0) < 3));
    end
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
